boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000, SHALL set the maximum number of idle cycles allowed between frame bytes.
REQ-002 Parameter IMEM_DEPTH, default 256, SHALL set the instruction-memory capacity in 16-bit words.
REQ-003 Parameter HEADER_BYTE, default 8'hA5, SHALL set the frame start marker.
REQ-004 Port sys_clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Port sys_rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-006 Port rx_data, input, 8, SHALL carry the received UART byte.
REQ-007 Port rx_valid, input, 1, SHALL be a one-cycle strobe qualifying rx_data.
REQ-008 Port reload_req, input, 1, SHALL request an abort and a restart of loading.
REQ-009 Port run_req, input, 1, SHALL request CPU start after a successful load.
REQ-010 Port imem_we, output, 1, SHALL be the instruction-memory write strobe.
REQ-011 Port imem_addr, output, 16, SHALL be the word write address.
REQ-012 Port imem_wdata, output, 16, SHALL be the write data as {MSB, LSB}.
REQ-013 Port cpu_rst, output, 1, SHALL be an active-high hold-in-reset signal to the CPU core.
REQ-014 Port cpu_run, output, 1, SHALL be the CPU run enable.
REQ-015 Port load_busy, output, 1, SHALL be high while a frame is in progress.
REQ-016 Port load_err, output, 1, SHALL be a sticky error flag.
REQ-017 Port words_loaded, output, 16, SHALL hold the count of words written so far.

Function
REQ-018 Frame format SHALL be: HEADER_BYTE, count LSB, count MSB, count x (word LSB, word MSB), checksum.
REQ-019 The checksum SHALL be the 8-bit modulo-256 sum of every byte after the header, excluding the checksum byte itself.
REQ-020 The FSM states SHALL be IDLE, CNT_L, CNT_H, DAT_L, DAT_H, CSUM, DONE, RUN and ERR.
REQ-021 In IDLE, a byte equal to HEADER_BYTE SHALL move the FSM to CNT_L; any other byte SHALL be ignored.
REQ-022 In CNT_H: count 0 SHALL go to CSUM; count > IMEM_DEPTH SHALL go to ERR; any other count SHALL go to DAT_L.
REQ-023 In DAT_H, rx_valid SHALL pulse imem_we high for exactly 1 cycle in the next cycle, with imem_addr = words_loaded (old value) and imem_wdata = {rx_data, stored LSB}.
REQ-024 imem_addr SHALL start at 0 and advance by 1 per word.
REQ-025 After the last word, the FSM SHALL go to CSUM; otherwise it SHALL return to DAT_L.
REQ-026 In CSUM, a match SHALL go to DONE and a mismatch SHALL go to ERR.
REQ-027 DONE SHALL keep cpu_rst=1; run_req in DONE SHALL go to RUN, with cpu_rst=0 and cpu_run=1 from the next cycle.
REQ-028 rx_valid in DONE, RUN or ERR SHALL be ignored.
REQ-029 The idle counter SHALL run only in CNT_L through CSUM, SHALL clear on each rx_valid, and SHALL send the FSM to ERR when it reaches TIMEOUT_CYCLES.
REQ-030 reload_req SHALL send any state to IDLE next cycle, clear load_err, words_loaded and the checksum, and set cpu_rst=1 and cpu_run=0.
REQ-031 reload_req SHALL take priority over a simultaneous rx_valid, run_req or timeout.
REQ-032 ERR SHALL hold load_err=1 and cpu_rst=1 until reload_req or reset.
REQ-033 load_busy SHALL be 1 exactly in states CNT_L through CSUM.
REQ-034 imem_we SHALL never assert outside DAT_H handling.

Reset
REQ-035 While sys_rst_n=0, the block SHALL hold: state IDLE, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, cpu_run 0, load_busy 0, load_err 0, words_loaded 0, and the idle counter and checksum at 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; no further imem_we SHALL occur.

Structure
REQ-037 The package boot_loader_pkg SHALL hold the state encoding, the HEADER_BYTE default and the TIMEOUT_CYCLES/IMEM_DEPTH defaults.
REQ-038 The idle counter SHALL be implemented as the sub-module byte_timeout_timer, with ports: clear, enable, expired.

Verification
REQ-039 Bench SHALL send A5 02 00 34 12 CD AB C0 -> writes (0,0x1234) and (1,0xABCD), then DONE with load_err=0 and words_loaded=2.
REQ-040 Bench SHALL send the same frame with checksum C1 -> ERR with load_err=1, cpu_rst=1 and two writes observed.
REQ-041 Bench SHALL send A5 01 01 (count 257) -> ERR immediately and no imem_we.
REQ-042 Bench SHALL send A5 01 00 34 and then stall TIMEOUT_CYCLES cycles -> ERR; then reload_req -> IDLE with load_err=0.
REQ-043 Bench SHALL send A5 00 00 00 followed by run_req -> DONE then RUN, with cpu_rst 1->0 and cpu_run=1.
REQ-044 Bench SHALL assert reload_req in the same cycle as the DAT_H rx_valid -> IDLE and no imem_we.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// ============================================================================
// Module   : boot_loader_pkg
// Purpose  : Shared state encoding and parameter defaults for the UART boot
//            loader controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_loader_pkg;

  localparam int unsigned c_timeout_cycles_def = 500000;
  localparam int unsigned c_imem_depth_def     = 256;
  localparam logic [7:0]  c_header_byte_def    = 8'hA5;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CNT_L = 4'd1,
    CNT_H = 4'd2,
    DAT_L = 4'd3,
    DAT_H = 4'd4,
    CSUM  = 4'd5,
    DONE  = 4'd6,
    RUN   = 4'd7,
    ERR   = 4'd8
  } state_t;

  // A frame is in flight from the count bytes up to the checksum byte.
  function automatic logic is_busy(input state_t s);
    return (s == CNT_L) || (s == CNT_H) || (s == DAT_L) ||
           (s == DAT_H) || (s == CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_timeout_timer.sv
// ============================================================================
// Module   : byte_timeout_timer
// Purpose  : Counts idle cycles between received bytes; flags expiry once the
//            count reaches TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_timeout_timer
  import boot_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned c_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_w-1:0] r_cnt;

  // Dropping enable also clears, so every new frame starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + c_w'(1);
    end
  end

  assign expired = (r_cnt == c_w'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
// ============================================================================
// Module   : boot_loader_ctrl
// Purpose  : Parses UART boot frames into instruction-memory writes and
//            sequences the CPU reset/run controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_def,
  parameter int unsigned IMEM_DEPTH     = c_imem_depth_def,
  parameter logic [7:0]  HEADER_BYTE    = c_header_byte_def
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload_req,
  input  logic        run_req,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_rst,
  output logic        cpu_run,
  output logic        load_busy,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [15:0] r_words, w_words_nxt;
  logic [15:0] r_addr,  w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [7:0]  r_csum,  w_csum_nxt;
  logic [7:0]  r_lsb,   w_lsb_nxt;
  logic        r_we,    w_we_nxt;

  logic        w_busy;
  logic        w_expired;
  logic        w_timer_clear;
  logic [15:0] w_cnt_rx;
  logic [15:0] w_words_inc;
  logic [7:0]  w_csum_add;

  assign w_busy        = is_busy(r_state);
  assign w_timer_clear = rx_valid | reload_req;
  assign w_cnt_rx      = {rx_data, r_count[7:0]};
  assign w_words_inc   = r_words + 16'd1;
  assign w_csum_add    = r_csum + rx_data;

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (w_timer_clear),
    .enable (w_busy),
    .expired(w_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_csum  <= '0;
      r_lsb   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_words <= w_words_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_csum  <= w_csum_nxt;
      r_lsb   <= w_lsb_nxt;
      r_we    <= w_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_words_nxt = r_words;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_csum_nxt  = r_csum;
    w_lsb_nxt   = r_lsb;
    w_we_nxt    = 1'b0;

    // Reload outranks everything, then timeout, then byte/run handling.
    if (reload_req) begin
      w_state_nxt = IDLE;
      w_words_nxt = '0;
      w_csum_nxt  = '0;
    end else if (w_busy && w_expired) begin
      w_state_nxt = ERR;
    end else begin
      if (rx_valid) begin
        case (r_state)
          IDLE: begin
            if (rx_data == HEADER_BYTE) begin
              w_state_nxt = CNT_L;
              w_words_nxt = '0;
              w_csum_nxt  = '0;
            end
          end
          CNT_L: begin
            w_count_nxt = {8'h00, rx_data};
            w_csum_nxt  = w_csum_add;
            w_state_nxt = CNT_H;
          end
          CNT_H: begin
            w_count_nxt = w_cnt_rx;
            w_csum_nxt  = w_csum_add;
            if (w_cnt_rx == 16'd0) begin
              w_state_nxt = CSUM;
            end else if ({1'b0, w_cnt_rx} > 17'(IMEM_DEPTH)) begin
              w_state_nxt = ERR;
            end else begin
              w_state_nxt = DAT_L;
            end
          end
          DAT_L: begin
            w_lsb_nxt   = rx_data;
            w_csum_nxt  = w_csum_add;
            w_state_nxt = DAT_H;
          end
          DAT_H: begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_words;
            w_wdata_nxt = {rx_data, r_lsb};
            w_words_nxt = w_words_inc;
            w_csum_nxt  = w_csum_add;
            w_state_nxt = (w_words_inc == r_count) ? CSUM : DAT_L;
          end
          CSUM: begin
            w_state_nxt = (rx_data == r_csum) ? DONE : ERR;
          end
          default: ;
        endcase
      end
      if ((r_state == DONE) && run_req) begin
        w_state_nxt = RUN;
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;
  assign load_busy    = w_busy;
  assign load_err     = (r_state == ERR);
  assign cpu_run      = (r_state == RUN);
  assign cpu_rst      = (r_state != RUN);

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
// ============================================================================
// Module   : tb_boot_loader_ctrl
// Purpose  : Self-checking bench for boot_loader_ctrl: directed frames plus
//            randomized frames checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_boot_loader_ctrl;

  localparam int unsigned TO    = 40;
  localparam int unsigned DEPTH = 256;
  localparam logic [7:0]  HDR   = 8'hA5;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic [7:0]  rx_data    = 8'h00;
  logic        rx_valid   = 1'b0;
  logic        reload_req = 1'b0;
  logic        run_req    = 1'b0;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_run;
  logic        load_busy;
  logic        load_err;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  frame[$];

  always #5 sys_clk = ~sys_clk;

  boot_loader_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .IMEM_DEPTH    (DEPTH),
    .HEADER_BYTE   (HDR)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .reload_req  (reload_req),
    .run_req     (run_req),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst     (cpu_rst),
    .cpu_run     (cpu_run),
    .load_busy   (load_busy),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always @(negedge sys_clk) begin
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge sys_clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame[i]) send_byte(frame[i], int'($urandom_range(0, maxgap)));
  endtask

  task automatic do_reload();
    @(posedge sys_clk); #1;
    reload_req = 1'b1;
    @(posedge sys_clk); #1;
    reload_req = 1'b0;
    wr_q.delete();
  endtask

  task automatic settle();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Frame-level reference: decode count, list expected writes, judge checksum.
  task automatic model_frame(output int exp_words, output logic exp_err);
    int cnt;
    logic [7:0] sum;
    exp_q.delete();
    cnt = int'(frame[1]) + 256 * int'(frame[2]);
    if (cnt > int'(DEPTH)) begin
      exp_err   = 1'b1;
      exp_words = 0;
      return;
    end
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({16'(i), frame[4 + 2 * i], frame[3 + 2 * i]});
    sum = 8'h00;
    for (int i = 1; i < frame.size() - 1; i++) sum = sum + frame[i];
    exp_err   = (sum != frame[frame.size() - 1]);
    exp_words = cnt;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    n_checks++; if (imem_we !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", imem_we); end
    n_checks++; if (imem_addr !== 16'h0) begin n_errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_checks++; if (imem_wdata !== 16'h0) begin n_errors++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_errors++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (cpu_run !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_run: got %b want 0", cpu_run); end
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", load_busy); end
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b want 0", load_err); end
    n_checks++; if (words_loaded !== 16'h0) begin n_errors++; $display("FAIL rst_words: got %h want 0", words_loaded); end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    wr_q.delete();
    send_byte(HDR, 0);
    @(negedge sys_clk);
    n_checks++; if (load_busy !== 1'b1) begin n_errors++; $display("FAIL good_busy: got %b want 1", load_busy); end
    frame = {8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC0};
    send_frame(2);
    settle();
    n_checks++;
    if (wr_q.size() !== 2) begin
      n_errors++; $display("FAIL good_nwr: got %0d want 2", wr_q.size());
    end else begin
      n_checks++; if (wr_q[0] !== 32'h0000_1234) begin n_errors++; $display("FAIL good_wr0: got %h want 00001234", wr_q[0]); end
      n_checks++; if (wr_q[1] !== 32'h0001_ABCD) begin n_errors++; $display("FAIL good_wr1: got %h want 0001abcd", wr_q[1]); end
    end
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL good_err: got %b want 0", load_err); end
    n_checks++; if (words_loaded !== 16'd2) begin n_errors++; $display("FAIL good_words: got %0d want 2", words_loaded); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_errors++; $display("FAIL good_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL good_busy_end: got %b want 0", load_busy); end
  endtask

  task automatic test_bad_csum();
    do_reload();
    frame = {HDR, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hC1};
    send_frame(1);
    settle();
    n_checks++; if (wr_q.size() !== 2) begin n_errors++; $display("FAIL bad_nwr: got %0d want 2", wr_q.size()); end
    n_checks++; if (load_err !== 1'b1) begin n_errors++; $display("FAIL bad_err: got %b want 1", load_err); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_errors++; $display("FAIL bad_cpu_rst: got %b want 1", cpu_rst); end
    send_byte(HDR, 0);
    @(negedge sys_clk);
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL err_ignore_busy: got %b want 0", load_busy); end
    n_checks++; if (load_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", load_err); end
  endtask

  task automatic test_overflow();
    do_reload();
    frame = {HDR, 8'h01, 8'h01};
    send_frame(0);
    @(negedge sys_clk);
    n_checks++; if (load_err !== 1'b1) begin n_errors++; $display("FAIL ovf_err: got %b want 1", load_err); end
    settle();
    n_checks++; if (wr_q.size() !== 0) begin n_errors++; $display("FAIL ovf_nwr: got %0d want 0", wr_q.size()); end
    n_checks++; if (words_loaded !== 16'd0) begin n_errors++; $display("FAIL ovf_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_timeout();
    int k;
    do_reload();
    frame = {HDR, 8'h01, 8'h00, 8'h34};
    send_frame(0);
    repeat (TO - 2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (load_busy !== 1'b1) begin n_errors++; $display("FAIL to_early: busy got %b want 1", load_busy); end
    k = 0;
    while (load_err !== 1'b1 && k < 8) begin
      @(negedge sys_clk);
      k++;
    end
    n_checks++; if (load_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b want 1 after %0d extra cycles", load_err, k); end
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL to_busy: got %b want 0", load_busy); end
    do_reload();
    @(negedge sys_clk);
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL to_reload_err: got %b want 0", load_err); end
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL to_reload_busy: got %b want 0", load_busy); end
    n_checks++; if (words_loaded !== 16'd0) begin n_errors++; $display("FAIL to_reload_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_run();
    do_reload();
    frame = {HDR, 8'h00, 8'h00, 8'h00};
    send_frame(1);
    settle();
    n_checks++; if (cpu_rst !== 1'b1) begin n_errors++; $display("FAIL done_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (cpu_run !== 1'b0) begin n_errors++; $display("FAIL done_cpu_run: got %b want 0", cpu_run); end
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL done_err: got %b want 0", load_err); end
    @(posedge sys_clk); #1;
    run_req = 1'b1;
    @(posedge sys_clk); #1;
    run_req = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (cpu_rst !== 1'b0) begin n_errors++; $display("FAIL run_cpu_rst: got %b want 0", cpu_rst); end
    n_checks++; if (cpu_run !== 1'b1) begin n_errors++; $display("FAIL run_cpu_run: got %b want 1", cpu_run); end
    send_byte(HDR, 0);
    @(negedge sys_clk);
    n_checks++; if (load_busy !== 1'b0 || cpu_run !== 1'b1) begin n_errors++; $display("FAIL run_ignore_rx: busy %b run %b want 0 1", load_busy, cpu_run); end
    do_reload();
    @(negedge sys_clk);
    n_checks++; if (cpu_rst !== 1'b1 || cpu_run !== 1'b0) begin n_errors++; $display("FAIL run_reload: rst %b run %b want 1 0", cpu_rst, cpu_run); end
  endtask

  task automatic test_reload_priority();
    do_reload();
    frame = {HDR, 8'h01, 8'h00, 8'h34};
    send_frame(0);
    @(posedge sys_clk); #1;
    rx_data    = 8'h12;
    rx_valid   = 1'b1;
    reload_req = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid   = 1'b0;
    reload_req = 1'b0;
    settle();
    n_checks++; if (wr_q.size() !== 0) begin n_errors++; $display("FAIL prio_nwr: got %0d want 0", wr_q.size()); end
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL prio_busy: got %b want 0", load_busy); end
    n_checks++; if (words_loaded !== 16'd0) begin n_errors++; $display("FAIL prio_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_reset_midframe();
    do_reload();
    frame = {HDR, 8'h02, 8'h00, 8'h34};
    send_frame(0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #2;
    n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy: got %b want 0", load_busy); end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    frame = {8'h12, 8'hCD, 8'hAB, 8'hC0};
    send_frame(1);
    settle();
    n_checks++; if (wr_q.size() !== 0) begin n_errors++; $display("FAIL mid_rst_nwr: got %0d want 0", wr_q.size()); end
    n_checks++; if (words_loaded !== 16'd0) begin n_errors++; $display("FAIL mid_rst_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_random();
    int          cnt;
    int          exp_words;
    logic        exp_err;
    logic [7:0]  sum;
    for (int f = 0; f < 24; f++) begin
      do_reload();
      frame.delete();
      if ($urandom_range(0, 7) == 0) cnt = int'($urandom_range(DEPTH + 1, DEPTH + 40));
      else                           cnt = int'($urandom_range(0, 8));
      frame.push_back(HDR);
      frame.push_back(8'(cnt));
      frame.push_back(8'(cnt >> 8));
      if (cnt <= int'(DEPTH)) begin
        for (int i = 0; i < 2 * cnt; i++) frame.push_back(8'($urandom));
        sum = 8'h00;
        for (int i = 1; i < frame.size(); i++) sum = sum + frame[i];
        if ($urandom_range(0, 3) == 0) sum = sum + 8'($urandom_range(1, 255));
        frame.push_back(sum);
      end
      model_frame(exp_words, exp_err);
      send_frame(3);
      settle();
      n_checks++;
      if (wr_q.size() !== exp_q.size()) begin
        n_errors++; $display("FAIL rnd%0d_nwr: got %0d want %0d", f, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_checks++;
          if (wr_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rnd%0d_wr%0d: got %h want %h", f, i, wr_q[i], exp_q[i]); end
        end
      end
      n_checks++; if (load_err !== exp_err) begin n_errors++; $display("FAIL rnd%0d_err: got %b want %b", f, load_err, exp_err); end
      n_checks++; if (words_loaded !== 16'(exp_words)) begin n_errors++; $display("FAIL rnd%0d_words: got %0d want %0d", f, words_loaded, exp_words); end
      n_checks++; if (load_busy !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_busy: got %b want 0", f, load_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_overflow();
    test_timeout();
    test_run();
    test_reload_priority();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
